acc_drain_requant: RTL

//  Downstream of the PE array. Once a tile's MACs finish, it reads each PE's 32-bit accumulator in turn.

---
 rtl/pe_pkg.sv | 43 ++++
 rtl/requant_core.sv | 67 ++++++
 rtl/acc_drain_requant.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/pe_pkg.sv
// Shared widths, drain FSM states and the int8 saturation helper for the
// accumulator drain / requantization path.
package pe_pkg;

  localparam int ACC_W   = 32;
  localparam int MULT_W  = 16;
  localparam int OUT_W   = 8;
  localparam int SHIFT_W = 5;
  localparam int PROD_W  = ACC_W + MULT_W;
  // One extra bit absorbs the rounding add, one more the zero-point add.
  localparam int Y_W     = PROD_W + 2;

  localparam logic signed [Y_W-1:0] SAT_MAX = Y_W'(2**(OUT_W-1) - 1);
  localparam logic signed [Y_W-1:0] SAT_MIN = Y_W'(-(2**(OUT_W-1)));

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    FLUSH,
    CLEAR
  } drain_state_e;

  typedef struct packed {
    logic             clip;
    logic [OUT_W-1:0] val;
  } sat_res_t;

  function automatic sat_res_t sat8(input logic signed [Y_W-1:0] y);
    sat_res_t res;
    if (y > SAT_MAX) begin
      res.clip = 1'b1;
      res.val  = SAT_MAX[OUT_W-1:0];
    end else if (y < SAT_MIN) begin
      res.clip = 1'b1;
      res.val  = SAT_MIN[OUT_W-1:0];
    end else begin
      res.clip = 1'b0;
      res.val  = y[OUT_W-1:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/requant_core.sv
// Requantization datapath: S2 multiplies, S3 rounds, shifts, adds the
// zero-point and saturates. Both stages freeze when adv is low.
module requant_core
  import pe_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     adv,
  input  logic                     in_valid,
  input  logic signed [ACC_W-1:0]  acc,
  input  logic signed [MULT_W-1:0] mult,
  input  logic [SHIFT_W-1:0]       shift,
  input  logic signed [OUT_W-1:0]  zp,
  output logic                     s2_valid,
  output logic                     out_valid,
  output logic signed [OUT_W-1:0]  out_data,
  output logic                     out_sat
);

  logic                     s2_valid_reg;
  logic signed [PROD_W-1:0] prod_reg;
  logic                     out_valid_reg;
  logic signed [OUT_W-1:0]  out_data_reg;
  logic                     out_sat_reg;

  logic signed [PROD_W-1:0] prod_next;
  logic signed [PROD_W:0]   round_bias;
  logic signed [PROD_W:0]   rounded_sum;
  logic signed [PROD_W:0]   shifted;
  logic signed [Y_W-1:0]    y_full;
  sat_res_t                 sat_res;

  always_comb begin
    prod_next  = PROD_W'(acc) * PROD_W'(mult);
    round_bias = '0;
    // Half-LSB bias before the arithmetic shift gives round-half-up.
    if (shift != '0) begin
      round_bias = (PROD_W+1)'(1) << (shift - SHIFT_W'(1));
    end
    rounded_sum = (PROD_W+1)'(prod_reg) + round_bias;
    shifted     = rounded_sum >>> shift;
    y_full      = Y_W'(shifted) + Y_W'(zp);
    sat_res     = sat8(y_full);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid_reg  <= 1'b0;
      prod_reg      <= '0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_sat_reg   <= 1'b0;
    end else if (adv) begin
      s2_valid_reg  <= in_valid;
      prod_reg      <= prod_next;
      out_valid_reg <= s2_valid_reg;
      out_data_reg  <= sat_res.val;
      out_sat_reg   <= sat_res.clip;
    end
  end

  assign s2_valid  = s2_valid_reg;
  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_sat   = out_sat_reg;

endmodule

// File: rtl/acc_drain_requant.sv
// Drains every PE accumulator of a finished tile through the requant
// pipeline, streams int8 results out and then clears the array.
module acc_drain_requant #(
  parameter int N_ACC  = 64,
  parameter int ACC_W  = pe_pkg::ACC_W,
  parameter int MULT_W = pe_pkg::MULT_W,
  parameter int OUT_W  = pe_pkg::OUT_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic signed [MULT_W-1:0]   cfg_mult,
  input  logic [4:0]                 cfg_shift,
  input  logic signed [OUT_W-1:0]    cfg_zp,
  output logic [$clog2(N_ACC)-1:0]   rd_idx,
  input  logic signed [ACC_W-1:0]    rd_data,
  output logic signed [OUT_W-1:0]    out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       acc_clr,
  output logic                       busy,
  output logic                       done,
  output logic [15:0]                sat_cnt
);

  import pe_pkg::*;

  localparam int IDX_W = $clog2(N_ACC);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ACC - 1);

  drain_state_e             state_reg, state_next;
  logic [IDX_W-1:0]         idx_reg, idx_next;
  logic                     s1_valid_reg, s1_valid_next;
  logic signed [ACC_W-1:0]  s1_data_reg;
  logic signed [MULT_W-1:0] mult_reg;
  logic [4:0]               shift_reg;
  logic signed [OUT_W-1:0]  zp_reg;
  logic [15:0]              sat_cnt_reg;

  logic                     adv;
  logic                     load_cfg;
  logic                     last_accept;
  logic                     core_s2_valid;
  logic                     core_out_valid;
  logic signed [OUT_W-1:0]  core_out_data;
  logic                     core_out_sat;

  // The only stall source is a presented result the consumer refuses.
  assign adv         = !(core_out_valid && !out_ready);
  assign last_accept = core_out_valid && out_ready && !s1_valid_reg && !core_s2_valid;

  always_comb begin
    state_next    = state_reg;
    idx_next      = idx_reg;
    load_cfg      = 1'b0;
    s1_valid_next = adv ? 1'b0 : s1_valid_reg;
    unique case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = DRAIN;
          idx_next   = '0;
          load_cfg   = 1'b1;
        end
      end
      DRAIN: begin
        if (adv) begin
          s1_valid_next = 1'b1;
          if (idx_reg == LAST_IDX) begin
            state_next = FLUSH;
          end else begin
            idx_next = idx_reg + IDX_W'(1);
          end
        end
      end
      FLUSH: begin
        if (last_accept) begin
          state_next = CLEAR;
        end
      end
      CLEAR: begin
        state_next = IDLE;
        idx_next   = '0;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      idx_reg      <= '0;
      s1_valid_reg <= 1'b0;
      s1_data_reg  <= '0;
      mult_reg     <= '0;
      shift_reg    <= '0;
      zp_reg       <= '0;
      sat_cnt_reg  <= '0;
    end else begin
      state_reg    <= state_next;
      idx_reg      <= idx_next;
      s1_valid_reg <= s1_valid_next;
      // rd_data follows rd_idx combinationally, so S1 samples it directly.
      if (adv) begin
        s1_data_reg <= rd_data;
      end
      if (load_cfg) begin
        mult_reg    <= cfg_mult;
        shift_reg   <= cfg_shift;
        zp_reg      <= cfg_zp;
        sat_cnt_reg <= '0;
      end else if (core_out_valid && out_ready && core_out_sat && sat_cnt_reg != 16'hFFFF) begin
        sat_cnt_reg <= sat_cnt_reg + 16'd1;
      end
    end
  end

  requant_core u_core (
    .clk      (clk),
    .rst      (rst),
    .adv      (adv),
    .in_valid (s1_valid_reg),
    .acc      (s1_data_reg),
    .mult     (mult_reg),
    .shift    (shift_reg),
    .zp       (zp_reg),
    .s2_valid (core_s2_valid),
    .out_valid(core_out_valid),
    .out_data (core_out_data),
    .out_sat  (core_out_sat)
  );

  assign rd_idx    = idx_reg;
  assign out_data  = core_out_data;
  assign out_valid = core_out_valid;
  assign acc_clr   = (state_reg == CLEAR);
  assign done      = (state_reg == CLEAR);
  assign busy      = (state_reg != IDLE);
  assign sat_cnt   = sat_cnt_reg;

endmodule
